// File: rtl/hazard_scheduler.sv
// Load-use stall and EX/MEM forwarding-select generator for a 5-stage pipeline.
// Optional build macro HAZARD_XZR_EN: register 31 is the zero register and never matches.

// One source operand: does it match the EX slot or the MEM slot?
module hazard_src_lane (
   input  logic [4:0] src,
   input  logic       ex_valid,
   input  logic       ex_wr,
   input  logic [4:0] ex_rd,
   input  logic       mem_valid,
   input  logic       mem_wr,
   input  logic [4:0] mem_rd,
   output logic       ex_hit,
   output logic       mem_hit
);
   logic zr;

`ifdef HAZARD_XZR_EN
   assign zr = (src == 5'd31);
`else
   assign zr = 1'b0;
`endif

   assign ex_hit  = ex_valid  & ex_wr  & (ex_rd  == src) & ~zr;
   assign mem_hit = mem_valid & mem_wr & (mem_rd == src) & ~zr;
endmodule

module hazard_scheduler #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rn,
   input  logic [4:0]       id_rm,
   input  logic [4:0]       id_rd,
   input  logic             id_wr,
   input  logic             id_load,
   input  logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int NUM_SRC = 2;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       load;
   } slot_t;

   slot_t ex_q, mem_q, id_slot;

   logic [NUM_SRC-1:0][4:0] src;
   logic [NUM_SRC-1:0]      ex_hit, mem_hit;
   logic [NUM_SRC-1:0][1:0] fwd_sel;
   logic                    stall_raw, fwd_ok;

   assign src     = {id_rm, id_rn};
   assign id_slot = '{valid: id_valid, rd: id_rd, wr: id_wr, load: id_load};

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         hazard_src_lane u_lane (
            .src       (src[g]),
            .ex_valid  (ex_q.valid),
            .ex_wr     (ex_q.wr),
            .ex_rd     (ex_q.rd),
            .mem_valid (mem_q.valid),
            .mem_wr    (mem_q.wr),
            .mem_rd    (mem_q.rd),
            .ex_hit    (ex_hit[g]),
            .mem_hit   (mem_hit[g])
         );

         // EX wins over MEM; a load in EX cannot forward, it stalls instead
         assign fwd_sel[g] = !fwd_ok                   ? 2'b00 :
                             (ex_hit[g] & ~ex_q.load) ? 2'b01 :
                             mem_hit[g]               ? 2'b10 : 2'b00;
      end
   endgenerate

   assign stall_raw = id_valid & ex_q.load & (|ex_hit);
   assign stall     = reset_n & stall_raw;
   assign fwd_ok    = reset_n & id_valid & ~stall_raw;
   assign fwd_a     = fwd_sel[0];
   assign fwd_b     = fwd_sel[1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         stall_cnt <= '0;
      end else if (flush) begin
         ex_q.valid  <= 1'b0;
         mem_q.valid <= 1'b0;
      end else begin
         mem_q <= ex_q;
         ex_q  <= stall ? slot_t'('0) : id_slot;
         if (stall && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // A stall only ever lasts one cycle: the bubble pushes the load into MEM
   a_single_stall : assert property (@(posedge clk) disable iff (!reset_n)
      (stall && !flush) |=> (mem_q.valid && mem_q.load && !stall));
endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: expected outputs queued per driven cycle, checked mid-cycle.
module tb_hazard_scheduler;
`ifdef HAZARD_XZR_EN
   localparam bit XZR = 1'b1;
`else
   localparam bit XZR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        id_valid = 1'b0, id_wr = 1'b0, id_load = 1'b0, flush = 1'b0;
   logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
   logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
   logic        stall, stall2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;

   typedef struct {
      logic        st;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [15:0] c16;
      logic [1:0]  c2;
      string       tag;
   } exp_t;

   exp_t sbq[$];
   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   c0;

   always #5 clk = ~clk;

   hazard_scheduler dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .flush(flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
   );

   hazard_scheduler #(.CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .flush(flush),
      .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall(stall2), .stall_cnt(stall_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // Drive one decode cycle at the falling edge, queue its expectation, check before the rising edge.
   task automatic step(input logic rst, input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic fl,
                       input logic es, input logic [1:0] efa, input logic [1:0] efb,
                       input int ec, input string tag);
      exp_t e, o;
      @(negedge clk);
      reset_n = rst; id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
      id_wr = wr; id_load = ld; flush = fl;
      e.st = es; e.fa = efa; e.fb = efb; e.c16 = 16'(ec);
      e.c2 = (ec > 3) ? 2'd3 : 2'(ec); e.tag = tag;
      sbq.push_back(e);
      #2;
      if (sbq.size() == 0) begin
         chk({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         o = sbq.pop_front();
         chk({o.tag, ".stall"},  {31'd0, stall},      {31'd0, o.st});
         chk({o.tag, ".fwd_a"},  {30'd0, fwd_a},      {30'd0, o.fa});
         chk({o.tag, ".fwd_b"},  {30'd0, fwd_b},      {30'd0, o.fb});
         chk({o.tag, ".cnt16"},  {16'd0, stall_cnt},  {16'd0, o.c16});
         chk({o.tag, ".cnt2"},   {30'd0, stall_cnt2}, {30'd0, o.c2});
         chk({o.tag, ".stall2"}, {31'd0, stall2},     {31'd0, o.st});
      end
   endtask

   initial begin
      // reset: a would-be load-use pair still yields all-zero outputs
      step(0, 1,  1,  1,  1, 1, 1, 0,  0, 2'd0, 2'd0, 0, "rst0");
      step(0, 1,  1,  1,  1, 1, 1, 0,  0, 2'd0, 2'd0, 0, "rst1");
      // ALU result forwarded from EX, then from MEM
      step(1, 1,  0,  0,  3, 1, 0, 0,  0, 2'd0, 2'd0, 0, "add_x3");
      step(1, 1,  3,  9,  0, 0, 0, 0,  0, 2'd1, 2'd0, 0, "ex_fwd");
      step(1, 1,  3,  3,  0, 0, 0, 0,  0, 2'd2, 2'd2, 0, "mem_fwd");
      // load-use: one stall then MEM forward on rm
      step(1, 1,  2,  2,  5, 1, 1, 0,  0, 2'd0, 2'd0, 0, "ldur_x5");
      step(1, 1,  6,  5,  8, 1, 0, 0,  1, 2'd0, 2'd0, 0, "lu_stall");
      step(1, 1,  6,  5,  8, 1, 0, 0,  0, 2'd0, 2'd2, 1, "lu_fwd");
      // EX and MEM both write X7: EX wins
      step(1, 1,  0,  0,  7, 1, 0, 0,  0, 2'd0, 2'd0, 1, "w7a");
      step(1, 1,  1,  1,  7, 1, 0, 0,  0, 2'd0, 2'd0, 1, "w7b");
      step(1, 1,  7,  7,  0, 0, 0, 0,  0, 2'd1, 2'd1, 1, "ex_pri");
      // load-use with flush: no count, slots emptied
      step(1, 1,  0,  0,  4, 1, 1, 0,  0, 2'd0, 2'd0, 1, "ld_x4");
      step(1, 1,  4,  0,  0, 0, 0, 1,  1, 2'd0, 2'd0, 1, "lu_flush");
      step(1, 1,  4,  4,  0, 0, 0, 0,  0, 2'd0, 2'd0, 1, "post_flush");
      // register 31
      step(1, 1,  0,  0, 31, 1, 0, 0,  0, 2'd0, 2'd0, 1, "add_x31");
      step(1, 1, 31,  0,  0, 0, 0, 0,  0, XZR ? 2'd0 : 2'd1, 2'd0, 1, "x31_ex");
      step(1, 1,  0, 31,  0, 0, 0, 0,  0, 2'd0, XZR ? 2'd0 : 2'd2, 1, "x31_mem");
      step(1, 1,  0,  0, 31, 1, 1, 0,  0, 2'd0, 2'd0, 1, "ld_x31");
      step(1, 1, 31, 31,  0, 0, 0, 0,  !XZR, 2'd0, 2'd0, 1, "x31_lu");
      c0 = XZR ? 1 : 2;
      step(1, 1, 31, 31,  0, 0, 0, 0,  0, XZR ? 2'd0 : 2'd2, XZR ? 2'd0 : 2'd2, c0, "x31_lu2");
      // chained load-use hazards: 16-bit counter keeps going, 2-bit one sticks at 3
      step(1, 1,  0,  0, 10, 1, 1, 0,  0, 2'd0, 2'd0, c0, "ld_x10");
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 5'(10 + k), 0, 5'(11 + k), 1, 1, 0, 1, 2'd0, 2'd0, c0 + k, "sat_st");
         step(1, 1, 5'(10 + k), 0, 5'(11 + k), 1, 1, 0, 0, 2'd2, 2'd0, c0 + k + 1, "sat_fw");
      end
      // reset lands mid-stall; the pending hazard must vanish
      step(1, 1, 15,  0,  0, 0, 0, 0,  1, 2'd0, 2'd0, c0 + 5, "rst_mid_st");
      step(0, 1, 15,  0,  0, 0, 0, 0,  0, 2'd0, 2'd0, c0 + 6, "rst_hold");
      step(1, 1, 15,  0,  0, 0, 0, 0,  0, 2'd0, 2'd0, 0, "post_rst");
      step(1, 0,  0,  0,  0, 0, 0, 0,  0, 2'd0, 2'd0, 0, "idle");
      chk("sbq_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
